// File: rtl/nn_controller_if.sv
// Host-side bus for nn_controller.
// Purpose : groups the pixel stream, weight/bias write port and prediction
//           handshake into one bundle.
// Signals : inputsInbound/inputPixel        pixel stream from host
//           weightWriteEnable/biasWriteEnable/LayerWriteSelect/
//           WriteAddressSelect/writeIn      parameter write port
//           predictionRecieved              host acknowledge
//           predictionReady/readyForInputs/predictionOut  controller status
// Modports: master = host side, slave = controller side.
interface nn_controller_if #(
  parameter int WRITE_IN_BIT_WIDTH = 40
);
  logic                          inputsInbound;
  logic                          predictionRecieved;
  logic                          inputPixel;
  logic                          weightWriteEnable;
  logic                          biasWriteEnable;
  logic                          LayerWriteSelect;
  logic [9:0]                    WriteAddressSelect;
  logic [WRITE_IN_BIT_WIDTH-1:0] writeIn;
  logic                          predictionReady;
  logic                          readyForInputs;
  logic [3:0]                    predictionOut;

  modport master (
    output inputsInbound, predictionRecieved, inputPixel,
    output weightWriteEnable, biasWriteEnable, LayerWriteSelect,
    output WriteAddressSelect, writeIn,
    input  predictionReady, readyForInputs, predictionOut
  );

  modport slave (
    input  inputsInbound, predictionRecieved, inputPixel,
    input  weightWriteEnable, biasWriteEnable, LayerWriteSelect,
    input  WriteAddressSelect, writeIn,
    output predictionReady, readyForInputs, predictionOut
  );
endinterface

// File: rtl/nn_controller.sv
// Two-layer binary-input neural-network classifier controller.
// Purpose : stores writable layer weights/biases, takes one binary pixel per
//           clock, runs hidden layer (accumulate + bias + ReLU), output layer
//           (MAC + bias) and argmax, then presents the winning class index
//           with a ready/received handshake.
// Ports   : masterClk  clock, all state on rising edge
//           reset      asynchronous active-low reset (weights are kept)
//           bus        nn_controller_if.slave (stream, write port, handshake)
module nn_controller #(
  parameter int INPUT_NODES        = 6,
  parameter int HIDDEN_NODES       = 4,
  parameter int OUTPUT_NODES       = 10,
  parameter int W1_WIDTH           = 4,
  parameter int W2_WIDTH           = 4,
  parameter int WRITE_IN_BIT_WIDTH = 40,
  parameter int OUT_ACC_WIDTH      = 16
) (
  input  logic           masterClk,
  input  logic           reset,
  nn_controller_if.slave bus
);

  // Hidden accumulator holds up to INPUT_NODES weights plus the bias.
  localparam int HACC_W = W1_WIDTH + $clog2(INPUT_NODES + 1) + 1;
  localparam int PIX_W  = (INPUT_NODES  > 1) ? $clog2(INPUT_NODES)  : 1;
  localparam int HID_W  = (HIDDEN_NODES > 1) ? $clog2(HIDDEN_NODES) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(INPUT_NODES - 1);
  localparam logic [HID_W-1:0] LAST_HID = HID_W'(HIDDEN_NODES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, L1_FIN, L2_MAC, L2_FIN, ARGMAX, DONE
  } stateT;

  stateT state, stateNext;

  // Parameter storage: not touched by reset.
  logic signed [W1_WIDTH-1:0] w1Mem [INPUT_NODES][HIDDEN_NODES];
  logic signed [W1_WIDTH-1:0] b1Mem [HIDDEN_NODES];
  logic signed [W2_WIDTH-1:0] w2Mem [HIDDEN_NODES][OUTPUT_NODES];
  logic signed [W2_WIDTH-1:0] b2Mem [OUTPUT_NODES];

  // Datapath state.
  logic signed [HACC_W-1:0]        hiddenAcc [HIDDEN_NODES];
  logic signed [OUT_ACC_WIDTH-1:0] outAcc    [OUTPUT_NODES];
  logic [PIX_W-1:0]                pixCnt;   // index of the next pixel to capture
  logic [HID_W-1:0]                macIdx;   // hidden node used by this MAC cycle
  logic [3:0]                      predReg;

  // Combinational helpers.
  logic signed [W1_WIDTH-1:0]      l1Field     [HIDDEN_NODES];
  logic signed [W2_WIDTH-1:0]      l2Field     [OUTPUT_NODES];
  logic signed [HACC_W-1:0]        hiddenAdd   [HIDDEN_NODES];
  logic signed [HACC_W-1:0]        hiddenBias  [HIDDEN_NODES];
  logic signed [HACC_W-1:0]        hiddenRelu  [HIDDEN_NODES];
  logic signed [OUT_ACC_WIDTH-1:0] macProd     [OUTPUT_NODES];
  logic signed [OUT_ACC_WIDTH-1:0] outBias     [OUTPUT_NODES];
  logic [HACC_W-1:0]               hiddenCur;
  logic signed [OUT_ACC_WIDTH-1:0] hiddenExt;
  logic [3:0]                      bestIdx;
  logic signed [OUT_ACC_WIDTH-1:0] bestVal;

  // ReLU output is non-negative, so it is zero-extended into the MAC.
  assign hiddenCur = hiddenAcc[macIdx];
  assign hiddenExt = OUT_ACC_WIDTH'($signed({1'b0, hiddenCur}));

  // Row unpacking: element 0 sits in the most significant slot.
  generate
    for (genvar gi = 0; gi < HIDDEN_NODES; gi++) begin : gHidden
      assign l1Field[gi]    = bus.writeIn[(HIDDEN_NODES-1-gi)*W1_WIDTH +: W1_WIDTH];
      assign hiddenAdd[gi]  = HACC_W'(w1Mem[pixCnt][gi]);
      assign hiddenBias[gi] = hiddenAcc[gi] + HACC_W'(b1Mem[gi]);
      assign hiddenRelu[gi] = hiddenBias[gi][HACC_W-1] ? '0 : hiddenBias[gi];
    end
    for (genvar gi = 0; gi < OUTPUT_NODES; gi++) begin : gOutput
      assign l2Field[gi] = bus.writeIn[(OUTPUT_NODES-1-gi)*W2_WIDTH +: W2_WIDTH];
      // Full-width signed multiply; truncation to OUT_ACC_WIDTH wraps.
      assign macProd[gi] = hiddenExt * OUT_ACC_WIDTH'(w2Mem[macIdx][gi]);
      assign outBias[gi] = outAcc[gi] + OUT_ACC_WIDTH'(b2Mem[gi]);
    end
  endgenerate

  // Parameter writes. Address is compared at full width so out-of-range
  // rows can never alias onto a valid one.
  always_ff @(posedge masterClk) begin
    if (bus.weightWriteEnable) begin
      if (!bus.LayerWriteSelect) begin
        for (int r = 0; r < INPUT_NODES; r++) begin
          if (bus.WriteAddressSelect == 10'(r)) begin
            for (int j = 0; j < HIDDEN_NODES; j++) w1Mem[r][j] <= l1Field[j];
          end
        end
      end else begin
        for (int r = 0; r < HIDDEN_NODES; r++) begin
          if (bus.WriteAddressSelect == 10'(r)) begin
            for (int k = 0; k < OUTPUT_NODES; k++) w2Mem[r][k] <= l2Field[k];
          end
        end
      end
    end
    if (bus.biasWriteEnable) begin
      if (!bus.LayerWriteSelect) begin
        for (int j = 0; j < HIDDEN_NODES; j++) b1Mem[j] <= l1Field[j];
      end else begin
        for (int k = 0; k < OUTPUT_NODES; k++) b2Mem[k] <= l2Field[k];
      end
    end
  end

  // Argmax: strict greater-than keeps the lowest index on ties.
  always_comb begin
    bestIdx = '0;
    bestVal = outAcc[0];
    for (int k = 1; k < OUTPUT_NODES; k++) begin
      if (outAcc[k] > bestVal) begin
        bestVal = outAcc[k];
        bestIdx = 4'(k);
      end
    end
  end

  // State register.
  always_ff @(posedge masterClk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state and status outputs.
  always_comb begin
    stateNext              = state;
    bus.readyForInputs     = 1'b0;
    bus.predictionReady    = 1'b0;
    bus.predictionOut      = predReg;
    case (state)
      IDLE: begin
        bus.readyForInputs = 1'b1;
        // pixCnt is 0 here, so a single-pixel image skips LOAD.
        if (bus.inputsInbound) stateNext = (pixCnt == LAST_PIX) ? L1_FIN : LOAD;
      end
      LOAD: begin
        if (!bus.inputsInbound || pixCnt == LAST_PIX) stateNext = L1_FIN;
      end
      L1_FIN: stateNext = L2_MAC;
      L2_MAC: if (macIdx == LAST_HID) stateNext = L2_FIN;
      L2_FIN: stateNext = ARGMAX;
      ARGMAX: stateNext = DONE;
      DONE: begin
        bus.predictionReady = 1'b1;
        if (bus.predictionRecieved) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge masterClk or negedge reset) begin
    if (!reset) begin
      pixCnt  <= '0;
      macIdx  <= '0;
      predReg <= '0;
      for (int j = 0; j < HIDDEN_NODES; j++) hiddenAcc[j] <= '0;
      for (int k = 0; k < OUTPUT_NODES; k++) outAcc[k]    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Pixel 0 is captured on the edge that leaves IDLE.
          for (int j = 0; j < HIDDEN_NODES; j++) begin
            hiddenAcc[j] <= (bus.inputsInbound && bus.inputPixel) ? hiddenAdd[j] : '0;
          end
          if (bus.inputsInbound) pixCnt <= (pixCnt == LAST_PIX) ? '0 : pixCnt + 1'b1;
        end
        LOAD: begin
          if (bus.inputsInbound) begin
            if (bus.inputPixel) begin
              for (int j = 0; j < HIDDEN_NODES; j++) begin
                hiddenAcc[j] <= hiddenAcc[j] + hiddenAdd[j];
              end
            end
            pixCnt <= (pixCnt == LAST_PIX) ? '0 : pixCnt + 1'b1;
          end else begin
            // Early drop: the missing pixels are zeros and add nothing.
            pixCnt <= '0;
          end
        end
        L1_FIN: begin
          for (int j = 0; j < HIDDEN_NODES; j++) hiddenAcc[j] <= hiddenRelu[j];
          for (int k = 0; k < OUTPUT_NODES; k++) outAcc[k]    <= '0;
          macIdx <= '0;
        end
        L2_MAC: begin
          for (int k = 0; k < OUTPUT_NODES; k++) outAcc[k] <= outAcc[k] + macProd[k];
          macIdx <= (macIdx == LAST_HID) ? '0 : macIdx + 1'b1;
        end
        L2_FIN: begin
          for (int k = 0; k < OUTPUT_NODES; k++) outAcc[k] <= outBias[k];
        end
        ARGMAX: predReg <= bestIdx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_controller.sv
// Self-checking bench for nn_controller: parameter loading, table of
// directed images with hand-computed class indices, latency, handshake,
// asynchronous reset mid-stream and out-of-range/simultaneous writes.
module tb_nn_controller;

  logic masterClk = 1'b0;
  logic reset     = 1'b1;
  always #5 masterClk = ~masterClk;

  nn_controller_if #(.WRITE_IN_BIT_WIDTH(40)) bus ();

  nn_controller #(
    .INPUT_NODES(6), .HIDDEN_NODES(4), .OUTPUT_NODES(10),
    .W1_WIDTH(4), .W2_WIDTH(4), .WRITE_IN_BIT_WIDTH(40), .OUT_ACC_WIDTH(16)
  ) dut (
    .masterClk(masterClk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int fails  = 0;

  int w1Tab [6][4] = '{'{1,6,7,5}, '{4,4,5,2}, '{6,6,5,1},
                       '{6,7,7,6}, '{1,3,5,5}, '{4,1,2,3}};
  int w2Tab [4][10] = '{'{ 3,-4, 7,-7, 6,-2, 0, 6,-1, 5},
                        '{-8, 3, 5,-5,-6,-1,-7, 2, 6,-3},
                        '{ 1,-3, 5,-8, 6, 3,-5, 4,-2,-4},
                        '{ 7, 2,-1,-6,-7, 3,-3,-8, 5, 0}};
  int b1Base [4]  = '{3, 7, 1, 2};
  int b1Neg  [4]  = '{-8, 7, -8, 7};
  int b1Off  [4]  = '{-1, -1, -1, -1};
  int b2Base [10] = '{0, 6, 2, 1, 3, 3, 4, 2, 0, 1};
  int b2Zero [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  typedef struct {
    int         biasSet;  // 0 base, 1 L1 [-8,7,-8,7], 2 tie, 3 L2 bias = w2 row 0
    logic [5:0] pix;      // pix[5] is pixel 0
    int         nPix;     // < 6 means inputsInbound drops early
    logic [3:0] expPred;
  } vecT;

  vecT vecs [11];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [39:0] pack4(input int v[4]);
    logic [39:0] r = '0;
    for (int k = 0; k < 4; k++) r[(3-k)*4 +: 4] = 4'(v[k]);
    return r;
  endfunction

  function automatic logic [39:0] pack10(input int v[10]);
    logic [39:0] r = '0;
    for (int k = 0; k < 10; k++) r[(9-k)*4 +: 4] = 4'(v[k]);
    return r;
  endfunction

  // Called one time unit after a rising edge; returns in the same phase.
  task automatic writeOp(input logic layer, input logic wEn, input logic bEn,
                         input logic [9:0] addr, input logic [39:0] data);
    bus.LayerWriteSelect   = layer;
    bus.weightWriteEnable  = wEn;
    bus.biasWriteEnable    = bEn;
    bus.WriteAddressSelect = addr;
    bus.writeIn            = data;
    @(posedge masterClk); #1;
    bus.weightWriteEnable  = 1'b0;
    bus.biasWriteEnable    = 1'b0;
  endtask

  task automatic setBias(input int sel);
    case (sel)
      0: begin writeOp(1'b0, 1'b0, 1'b1, 10'h3FF, pack4(b1Base)); writeOp(1'b1, 1'b0, 1'b1, 10'h3FF, pack10(b2Base)); end
      1: begin writeOp(1'b0, 1'b0, 1'b1, 10'h3FF, pack4(b1Neg));  writeOp(1'b1, 1'b0, 1'b1, 10'h3FF, pack10(b2Base)); end
      2: begin writeOp(1'b0, 1'b0, 1'b1, 10'h3FF, pack4(b1Off));  writeOp(1'b1, 1'b0, 1'b1, 10'h3FF, pack10(b2Zero)); end
      default: begin
        writeOp(1'b0, 1'b0, 1'b1, 10'h3FF, pack4(b1Off));
        // Weight row 0 and bias in one cycle: both take the same data.
        writeOp(1'b1, 1'b1, 1'b1, 10'd0, pack10(w2Tab[0]));
      end
    endcase
  endtask

  // Streams an image, checks the busy flag and the 7-edge latency.
  task automatic runVector(input string name, input logic [5:0] pix, input int nPix);
    int latency;
    for (int i = 0; i < nPix; i++) begin
      bus.inputsInbound = 1'b1;
      bus.inputPixel    = pix[5-i];
      @(posedge masterClk); #1;
    end
    bus.inputsInbound = 1'b0;
    bus.inputPixel    = 1'b0;
    if (nPix < 6) begin
      @(posedge masterClk); #1;
    end
    latency = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge masterClk); #1;
      if (c == 3) check({name, "_busy_rfi"}, 32'(bus.readyForInputs), 32'd0);
      if (bus.predictionReady) begin
        latency = c;
        break;
      end
    end
    check({name, "_latency"}, 32'(latency), 32'd7);
  endtask

  task automatic ack();
    bus.predictionRecieved = 1'b1;
    @(posedge masterClk); #1;
    bus.predictionRecieved = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0, 6'b011010, 6, 4'd2};
    vecs[1]  = '{0, 6'b000000, 6, 4'd2};
    vecs[2]  = '{0, 6'b011000, 3, 4'd2};
    vecs[3]  = '{1, 6'b000000, 6, 4'd8};
    vecs[4]  = '{1, 6'b111111, 6, 4'd2};
    vecs[5]  = '{1, 6'b100000, 6, 4'd8};
    vecs[6]  = '{1, 6'b110100, 6, 4'd8};
    vecs[7]  = '{1, 6'b001000, 6, 4'd8};
    vecs[8]  = '{1, 6'b101000, 3, 4'd8};
    vecs[9]  = '{3, 6'b000000, 6, 4'd2};
    vecs[10] = '{2, 6'b000000, 6, 4'd0};

    bus.inputsInbound      = 1'b0;
    bus.predictionRecieved = 1'b0;
    bus.inputPixel         = 1'b0;
    bus.weightWriteEnable  = 1'b0;
    bus.biasWriteEnable    = 1'b0;
    bus.LayerWriteSelect   = 1'b0;
    bus.WriteAddressSelect = '0;
    bus.writeIn            = '0;

    // Power-on reset.
    #2 reset = 1'b0;
    #1;
    check("rst_predReady", 32'(bus.predictionReady), 32'd0);
    check("rst_readyIn",   32'(bus.readyForInputs),  32'd1);
    check("rst_predOut",   32'(bus.predictionOut),   32'd0);
    repeat (2) @(posedge masterClk);
    #3 reset = 1'b1;
    @(posedge masterClk); #1;

    // Weight load, then writes that must be ignored (addresses would alias
    // onto row 0 if truncated).
    for (int r = 0; r < 6; r++) writeOp(1'b0, 1'b1, 1'b0, 10'(r), pack4(w1Tab[r]));
    for (int r = 0; r < 4; r++) writeOp(1'b1, 1'b1, 1'b0, 10'(r), pack10(w2Tab[r]));
    writeOp(1'b0, 1'b1, 1'b0, 10'd8,  40'h88888_88888);
    writeOp(1'b1, 1'b1, 1'b0, 10'd4,  40'h88888_88888);
    writeOp(1'b0, 1'b1, 1'b0, 10'd64, 40'h88888_88888);

    // Reference inference plus handshake hold.
    setBias(0);
    runVector("ref", 6'b011010, 6);
    check("ref_pred", 32'(bus.predictionOut), 32'd2);
    $display("ref image 011010 -> class %0d", bus.predictionOut);
    for (int c = 0; c < 5; c++) begin
      @(posedge masterClk); #1;
      check("hold_ready", 32'(bus.predictionReady), 32'd1);
    end
    ack();
    check("ack_ready",   32'(bus.predictionReady), 32'd0);
    check("ack_readyIn", 32'(bus.readyForInputs),  32'd1);
    check("ack_predOut", 32'(bus.predictionOut),   32'd2);

    // Asynchronous reset mid-LOAD.
    for (int i = 0; i < 3; i++) begin
      bus.inputsInbound = 1'b1;
      bus.inputPixel    = (i != 0);
      @(posedge masterClk); #1;
    end
    #2 reset = 1'b0;
    #1;
    check("midrst_predReady", 32'(bus.predictionReady), 32'd0);
    check("midrst_readyIn",   32'(bus.readyForInputs),  32'd1);
    check("midrst_predOut",   32'(bus.predictionOut),   32'd0);
    bus.inputsInbound = 1'b0;
    bus.inputPixel    = 1'b0;
    repeat (2) @(posedge masterClk);
    #3 reset = 1'b1;
    @(posedge masterClk); #1;
    $display("async reset mid-stream applied and released");

    // Table of directed images.
    for (int v = 0; v < 11; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      setBias(vecs[v].biasSet);
      runVector(nm, vecs[v].pix, vecs[v].nPix);
      check({nm, "_pred"}, 32'(bus.predictionOut), 32'(vecs[v].expPred));
      $display("vec %0d bias=%0d pixels=%b n=%0d -> class %0d (expected %0d)",
               v, vecs[v].biasSet, vecs[v].pix, vecs[v].nPix,
               bus.predictionOut, vecs[v].expPred);
      ack();
      check({nm, "_idle"}, 32'(bus.readyForInputs), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/nn_controller.md
Name: nn_controller

Overview:
- Top-level controller for a two-layer binary-input neural-network classifier.
- Holds writable layer weights and biases, and accepts one binary pixel per clock.
- Computes hidden layer (accumulate + bias + ReLU), then output layer (MAC + bias), then argmax.
- Presents the winning class index with a ready/received handshake to the host.

Parameters:
INPUT_NODES, 6, number of input pixels per inference
HIDDEN_NODES, 4, layer-1 output / layer-2 input nodes
OUTPUT_NODES, 10, output classes (digits)
W1_WIDTH, 4, signed two's-complement width of layer-1 weights and biases
W2_WIDTH, 4, signed two's-complement width of layer-2 weights and biases
WRITE_IN_BIT_WIDTH, 40, write data bus width; must be ≥ max(HIDDEN_NODES*W1_WIDTH, OUTPUT_NODES*W2_WIDTH)
OUT_ACC_WIDTH, 16, signed output accumulator width

Ports:
masterClk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
inputsInbound  in  1  high while pixels are being streamed
predictionRecieved  in  1  host acknowledges prediction
inputPixel  in  1  current binary pixel
weightWriteEnable  in  1  write weight row
biasWriteEnable  in  1  write bias row
LayerWriteSelect  in  1  0 = layer 1, 1 = layer 2
WriteAddressSelect  in  10  row address; layer 1 = input pixel index, layer 2 = hidden node index
writeIn  in  WRITE_IN_BIT_WIDTH  packed row data
predictionReady  out  1  prediction valid
readyForInputs  out  1  idle, accepting a new image
predictionOut  out  4  argmax class index

Behaviour:
- Row packing: row of N elements of width W occupies writeIn[N*W-1:0]. Element 0 is in the most significant slot: element k = writeIn[(N-1-k)*W +: W]. Upper bits are ignored.
- Layer-1 weight row a (a < INPUT_NODES): HIDDEN_NODES weights; element j = weight from pixel a to hidden j.
- Layer-2 weight row a (a < HIDDEN_NODES): OUTPUT_NODES weights; element k = weight from hidden a to output k.
- Bias row (address ignored): HIDDEN_NODES (layer 1) or OUTPUT_NODES (layer 2) elements.
- Writes are sampled on the rising edge while the enable is high. Out-of-range addresses are ignored. Weight and bias writes in the same cycle are both performed.
- Writes are accepted in every state. Writing during an inference gives an undefined result for that inference.
- Weight and bias storage is not cleared by reset. Reset clears FSM, counters, accumulators and outputs only.
- Reset values: predictionReady=0, readyForInputs=1, predictionOut=0, state IDLE.
- FSM states: IDLE → LOAD → L1_FIN → L2_MAC → L2_FIN → ARGMAX → DONE.
- IDLE: readyForInputs=1, hidden accumulators=0. On an edge with inputsInbound=1, capture that pixel as index 0 and go to LOAD.
- LOAD: each edge with inputsInbound=1 captures the next pixel. For pixel i=1, each hidden_j += w1[i][j]; pixel 0 adds nothing.
  - After pixel INPUT_NODES-1 is captured, go to L1_FIN; further inputsInbound is ignored.
  - If inputsInbound drops early, the remaining pixels count as 0 and the FSM goes to L1_FIN.
- L1_FIN (1 cycle): hidden_j = ReLU(hidden_j + b1[j]). Accumulator width is W1_WIDTH + clog2(INPUT_NODES+1) + 1 signed. ReLU result is treated as unsigned.
- L2_MAC (HIDDEN_NODES cycles): cycle j does out_k += hidden_j * w2[j][k] for all k in parallel. Arithmetic is signed in OUT_ACC_WIDTH with wraparound.
- L2_FIN (1 cycle): out_k += b2[k].
- ARGMAX (1 cycle): register the index of the maximum signed out_k. Ties go to the lowest index.
- Latency: predictionReady rises HIDDEN_NODES+3 edges after the edge capturing the last pixel (7 with defaults).
- DONE: predictionReady=1, predictionOut stable.
  - predictionRecieved=1 at an edge → IDLE on that edge: predictionReady=0, readyForInputs=1.
  - predictionOut holds its value until the next ARGMAX.
- readyForInputs=0 in every state except IDLE.
- Async reset assertion mid-inference aborts to IDLE immediately. Weights are retained.

Test Plan:
- Reset: assert reset low mid-LOAD → predictionReady=0, readyForInputs=1, predictionOut=0 immediately; previously written weights still produce correct results afterwards.
- Full inference, write phase:
  - L1 rows 0..5 = [1,6,7,5],[4,4,5,2],[6,6,5,1],[6,7,7,6],[1,3,5,5],[4,1,2,3]; L1 bias [3,7,1,2].
  - L2 rows 0..3 = (3,-4,7,-7,6,-2,0,6,-1,5), (-8,3,5,-5,-6,-1,-7,2,6,-3), (1,-3,5,-8,6,3,-5,4,-2,-4), (7,2,-1,-6,-7,3,-3,-8,5,0); L2 bias (0,6,2,1,3,3,4,2,0,1).
- Full inference, stream and check:
  - Pixels 0,1,1,0,1,0 → hidden [14,20,16,10]; outputs (-32,-18,270,-385,-7,33,-246,110,124,-53).
  - predictionOut=2 and predictionReady=1 exactly 7 edges after the last pixel.
- Handshake: hold predictionRecieved=0 for 5 cycles → predictionReady stays 1; pulse it → next edge predictionReady=0, readyForInputs=1, predictionOut stays 2.
- ReLU/tie: all pixels 0, L1 bias [-1,-1,-1,-1], L2 bias all 0 → all outputs 0 → predictionOut=0.
- Early drop: inputsInbound low after 3 pixels (0,1,1) → processed as 0,1,1,0,0,0; result matches the reference computation.
